// File: rtl/execute_csr_rmw.sv
// CSR read-modify-write execute unit: CSRRW/S/C and immediate forms.
// Reads the CSR bus, writes back over a ready/valid channel, reports to writeback.
module execute_csr_rmw #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit CHECK_PRIV     = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [6:0]      decode_opcode,
  input  logic [2:0]      decode_funct3,
  input  logic [4:0]      decode_rd,
  input  logic [4:0]      decode_rs1,
  input  logic [11:0]     decode_imm,
  input  logic [XLEN-1:0] read_rs1_val,
  input  logic            read_valid,
  input  logic [1:0]      cur_priv,
  output logic [11:0]     csrbus_araddr,
  output logic            csrbus_arvalid,
  input  logic [XLEN-1:0] csrbus_rdata,
  input  logic [1:0]      csrbus_rresp,
  input  logic            csrbus_rvalid,
  output logic [11:0]     csr_write_addr,
  output logic [XLEN-1:0] csr_write_val,
  output logic            csr_write_valid,
  input  logic            csr_write_ready,
  output logic            processing,
  output logic            valid,
  output logic [XLEN-1:0] rd_val_out,
  output logic [5:0]      exception_num_out,
  output logic            exception_valid_out
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] op_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] last_q;
  logic [1:0]      wsel_q;
  logic            do_read_q;
  logic            do_write_q;
  logic            exc_q;

  logic            known;
  logic            accept;
  logic            acc_rd;
  logic            acc_wr;
  logic            priv_fail;
  logic            tmo_hit;
  logic [XLEN-1:0] acc_op;
  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] resp_val;

  always_comb begin
    known  = (decode_opcode == 7'b1110011)
           && (decode_funct3[1:0] != 2'b00);
    accept = (state_q == IDLE) && read_valid
           && known && !flush;
    // funct3[1] set means S/C forms, which always read
    acc_rd = (decode_rd != 5'd0) || decode_funct3[1];
    acc_wr = !decode_funct3[1] || (decode_rs1 != 5'd0);
    priv_fail = CHECK_PRIV
      && ((acc_wr && (decode_imm[11:10] == 2'b11))
          || (decode_imm[9:8] > cur_priv));
    acc_op = decode_funct3[2]
           ? {{(XLEN-5){1'b0}}, decode_rs1}
           : read_rs1_val;
    tmo_hit = (TIMEOUT_CYCLES != 0)
           && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (priv_fail)   state_d = RESP;
          else if (acc_rd) state_d = READ;
          else             state_d = WRITE;
        end
      end
      READ: begin
        if (csrbus_rvalid) begin
          if (csrbus_rresp != 2'b00 || !do_write_q)
            state_d = RESP;
          else
            state_d = WRITE;
        end else if (tmo_hit) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: if (csr_write_ready) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      op_q       <= '0;
      rdata_q    <= '0;
      last_q     <= '0;
      wsel_q     <= '0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q     <= decode_imm;
        op_q       <= acc_op;
        rdata_q    <= '0;
        wsel_q     <= decode_funct3[1:0];
        do_read_q  <= acc_rd;
        do_write_q <= acc_wr;
        exc_q      <= priv_fail;
      end
      if (state_q == READ) begin
        if (csrbus_rvalid) begin
          if (csrbus_rresp == 2'b00) rdata_q <= csrbus_rdata;
          else                       exc_q   <= 1'b1;
        end else if (tmo_hit) begin
          exc_q <= 1'b1;
        end
      end
      if (state_q == RESP && !flush) last_q <= resp_val;
    end
  end

  always_comb begin
    unique case (wsel_q)
      2'b10:   wval = rdata_q | op_q;
      2'b11:   wval = rdata_q & ~op_q;
      default: wval = op_q;
    endcase
    resp_val = do_read_q ? rdata_q : '0;
  end

  always_comb begin
    processing = !flush && (accept || state_q != IDLE);
    csrbus_arvalid  = (state_q == READ) && !flush;
    csrbus_araddr   = csrbus_arvalid ? addr_q : '0;
    csr_write_valid = (state_q == WRITE) && !flush;
    csr_write_addr  = csr_write_valid ? addr_q : '0;
    csr_write_val   = csr_write_valid ? wval : '0;
    valid = (state_q == RESP) && !flush;
    exception_valid_out = valid && exc_q;
    exception_num_out = exception_valid_out ? 6'd2 : 6'd0;
    rd_val_out = (state_q == RESP) ? resp_val : last_q;
  end

endmodule

// File: tb/tb_execute_csr_rmw.sv
// Directed bench for execute_csr_rmw.
// Inputs change at the falling edge; outputs are checked there.
module tb_execute_csr_rmw;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [6:0]  decode_opcode;
  logic [2:0]  decode_funct3;
  logic [4:0]  decode_rd, decode_rs1;
  logic [11:0] decode_imm;
  logic [31:0] read_rs1_val;
  logic        read_valid;
  logic [1:0]  cur_priv;
  logic [11:0] csrbus_araddr;
  logic        csrbus_arvalid;
  logic [31:0] csrbus_rdata;
  logic [1:0]  csrbus_rresp;
  logic        csrbus_rvalid;
  logic [11:0] csr_write_addr;
  logic [31:0] csr_write_val;
  logic        csr_write_valid, csr_write_ready;
  logic        processing, valid;
  logic [31:0] rd_val_out;
  logic [5:0]  exception_num_out;
  logic        exception_valid_out;

  int n_cmp = 0;
  int n_bad = 0;
  int ar_n = 0, wr_n = 0, vld_n = 0;
  int b_ar, b_wr, b_vld;
  logic [31:0] wr_last = '0;

  execute_csr_rmw #(
    .XLEN(32), .TIMEOUT_CYCLES(16), .CHECK_PRIV(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .decode_opcode(decode_opcode),
    .decode_funct3(decode_funct3),
    .decode_rd(decode_rd), .decode_rs1(decode_rs1),
    .decode_imm(decode_imm),
    .read_rs1_val(read_rs1_val),
    .read_valid(read_valid), .cur_priv(cur_priv),
    .csrbus_araddr(csrbus_araddr),
    .csrbus_arvalid(csrbus_arvalid),
    .csrbus_rdata(csrbus_rdata),
    .csrbus_rresp(csrbus_rresp),
    .csrbus_rvalid(csrbus_rvalid),
    .csr_write_addr(csr_write_addr),
    .csr_write_val(csr_write_val),
    .csr_write_valid(csr_write_valid),
    .csr_write_ready(csr_write_ready),
    .processing(processing), .valid(valid),
    .rd_val_out(rd_val_out),
    .exception_num_out(exception_num_out),
    .exception_valid_out(exception_valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (csrbus_arvalid) ar_n <= ar_n + 1;
    if (valid) vld_n <= vld_n + 1;
    if (csr_write_valid && csr_write_ready) begin
      wr_n    <= wr_n + 1;
      wr_last <= csr_write_val;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(logic [2:0] f3, logic [4:0] rd,
                       logic [4:0] rs1, logic [31:0] v,
                       logic [11:0] a);
    decode_opcode = 7'b1110011;
    decode_funct3 = f3;
    decode_rd     = rd;
    decode_rs1    = rs1;
    read_rs1_val  = v;
    decode_imm    = a;
    read_valid    = 1'b1;
  endtask

  task automatic base();
    b_ar  = ar_n;
    b_wr  = wr_n;
    b_vld = vld_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    decode_opcode = '0; decode_funct3 = '0;
    decode_rd = '0; decode_rs1 = '0; decode_imm = '0;
    read_rs1_val = '0; read_valid = 1'b0; cur_priv = 2'd3;
    csrbus_rdata = '0; csrbus_rresp = '0;
    csrbus_rvalid = 1'b0; csr_write_ready = 1'b1;
    step(); step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_proc", 32'(processing), 32'd0);
    chk("rst_ar", 32'(csrbus_arvalid), 32'd0);
    chk("rst_wv", 32'(csr_write_valid), 32'd0);
    chk("rst_rd", rd_val_out, 32'd0);
    reset = 1'b0;
    step();

    // CSRRS x5, 0x300, x3
    base();
    issue(3'b010, 5'd5, 5'd3, 32'h0000_00F0, 12'h300);
    #1 chk("s_proc_acc", 32'(processing), 32'd1);
    step();
    read_valid = 1'b0; decode_imm = 12'h0;
    decode_funct3 = 3'b001; read_rs1_val = '0;
    #1 chk("s_ar", 32'(csrbus_arvalid), 32'd1);
    chk("s_araddr", 32'(csrbus_araddr), 32'h300);
    step();
    chk("s_ar_hold", 32'(csrbus_arvalid), 32'd1);
    csrbus_rvalid = 1'b1; csrbus_rdata = 32'h0000_000F;
    step();
    csrbus_rvalid = 1'b0; csrbus_rdata = '0;
    #1 chk("s_wv", 32'(csr_write_valid), 32'd1);
    chk("s_waddr", 32'(csr_write_addr), 32'h300);
    chk("s_wval", csr_write_val, 32'h0000_00FF);
    step();
    chk("s_valid", 32'(valid), 32'd1);
    chk("s_rd", rd_val_out, 32'h0000_000F);
    chk("s_exc", 32'(exception_valid_out), 32'd0);
    step();
    chk("s_valid_end", 32'(valid), 32'd0);
    chk("s_rd_hold", rd_val_out, 32'h0000_000F);
    chk("s_wr_cnt", 32'(wr_n - b_wr), 32'd1);
    chk("s_vld_cnt", 32'(vld_n - b_vld), 32'd1);

    // reset in the middle of a read
    issue(3'b010, 5'd5, 5'd3, 32'h0000_00F0, 12'h300);
    step();
    read_valid = 1'b0;
    #1 chk("r_ar", 32'(csrbus_arvalid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_ar0", 32'(csrbus_arvalid), 32'd0);
    chk("r_araddr0", 32'(csrbus_araddr), 32'd0);
    chk("r_proc0", 32'(processing), 32'd0);
    chk("r_rd0", rd_val_out, 32'd0);
    step();

    // CSRRW x0, 0x340, x0: write only, ready delayed
    csr_write_ready = 1'b0;
    issue(3'b001, 5'd0, 5'd0, 32'd0, 12'h340);
    step();
    read_valid = 1'b0;
    base();
    chk("w_wv", 32'(csr_write_valid), 32'd1);
    chk("w_waddr", 32'(csr_write_addr), 32'h340);
    chk("w_wval", csr_write_val, 32'd0);
    chk("w_noar", 32'(csrbus_arvalid), 32'd0);
    step(); step();
    chk("w_wv_held", 32'(csr_write_valid), 32'd1);
    chk("w_waddr_held", 32'(csr_write_addr), 32'h340);
    csr_write_ready = 1'b1;
    step();
    chk("w_valid", 32'(valid), 32'd1);
    chk("w_rd", rd_val_out, 32'd0);
    chk("w_exc", 32'(exception_valid_out), 32'd0);
    chk("w_ar_cnt", 32'(ar_n - b_ar), 32'd0);
    chk("w_wr_cnt", 32'(wr_n - b_wr), 32'd1);
    step();

    // CSRRWI to read-only 0xC00
    base();
    issue(3'b101, 5'd1, 5'd5, 32'd0, 12'hC00);
    step();
    read_valid = 1'b0;
    chk("ro_valid", 32'(valid), 32'd1);
    chk("ro_exc", 32'(exception_valid_out), 32'd1);
    chk("ro_num", 32'(exception_num_out), 32'd2);
    step();
    chk("ro_num_end", 32'(exception_num_out), 32'd0);
    chk("ro_ar_cnt", 32'(ar_n - b_ar), 32'd0);
    chk("ro_wr_cnt", 32'(wr_n - b_wr), 32'd0);

    // CSRRC in user mode on a machine CSR
    cur_priv = 2'd0;
    issue(3'b011, 5'd3, 5'd2, 32'h0000_FFFF, 12'h300);
    step();
    read_valid = 1'b0;
    chk("pv_valid", 32'(valid), 32'd1);
    chk("pv_exc", 32'(exception_valid_out), 32'd1);
    chk("pv_num", 32'(exception_num_out), 32'd2);
    step();
    cur_priv = 2'd3;

    // CSRRC with an error response
    base();
    issue(3'b011, 5'd3, 5'd2, 32'h0000_FFFF, 12'h300);
    step();
    read_valid = 1'b0;
    chk("er_ar", 32'(csrbus_arvalid), 32'd1);
    csrbus_rvalid = 1'b1; csrbus_rresp = 2'b10;
    csrbus_rdata = 32'h1234_5678;
    step();
    csrbus_rvalid = 1'b0; csrbus_rresp = 2'b00;
    csrbus_rdata = '0;
    chk("er_exc", 32'(exception_valid_out), 32'd1);
    chk("er_num", 32'(exception_num_out), 32'd2);
    chk("er_wv", 32'(csr_write_valid), 32'd0);
    step();
    chk("er_wr_cnt", 32'(wr_n - b_wr), 32'd0);

    // read timeout, then a late response
    base();
    issue(3'b010, 5'd1, 5'd0, 32'd0, 12'h340);
    step();
    read_valid = 1'b0;
    repeat (15) step();
    chk("to_ar_last", 32'(csrbus_arvalid), 32'd1);
    step();
    chk("to_ar_drop", 32'(csrbus_arvalid), 32'd0);
    chk("to_valid", 32'(valid), 32'd1);
    chk("to_exc", 32'(exception_valid_out), 32'd1);
    chk("to_num", 32'(exception_num_out), 32'd2);
    chk("to_ar_cnt", 32'(ar_n - b_ar), 32'd16);
    step();
    csrbus_rvalid = 1'b1; csrbus_rdata = 32'hDEAD_BEEF;
    step();
    csrbus_rvalid = 1'b0; csrbus_rdata = '0;
    chk("late_valid", 32'(valid), 32'd0);
    chk("late_proc", 32'(processing), 32'd0);
    step();
    chk("late_vld_cnt", 32'(vld_n - b_vld), 32'd1);

    // flush while a write waits, then a clean retry
    base();
    csr_write_ready = 1'b0;
    issue(3'b001, 5'd0, 5'd1, 32'h0000_A5A5, 12'h340);
    step();
    read_valid = 1'b0;
    chk("fl_wv", 32'(csr_write_valid), 32'd1);
    flush = 1'b1; csr_write_ready = 1'b1;
    #1 chk("fl_wv_drop", 32'(csr_write_valid), 32'd0);
    chk("fl_proc", 32'(processing), 32'd0);
    step();
    flush = 1'b0;
    #1 chk("fl_valid", 32'(valid), 32'd0);
    chk("fl_idle_wv", 32'(csr_write_valid), 32'd0);
    chk("fl_wr_cnt", 32'(wr_n - b_wr), 32'd0);
    chk("fl_vld_cnt", 32'(vld_n - b_vld), 32'd0);
    issue(3'b001, 5'd0, 5'd1, 32'h0000_A5A5, 12'h340);
    step();
    read_valid = 1'b0;
    chk("rt_wval", csr_write_val, 32'h0000_A5A5);
    step();
    chk("rt_valid", 32'(valid), 32'd1);
    chk("rt_exc", 32'(exception_valid_out), 32'd0);
    step();
    chk("rt_wr_cnt", 32'(wr_n - b_wr), 32'd1);
    chk("rt_wr_last", wr_last, 32'h0000_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_csr_rmw.md
Name: execute_csr_rmw

Overview:
- Parametrised successor to the CSR execute unit: executes CSRRW/CSRRS/CSRRC and their immediate forms (SYSTEM opcode 7'b1110011).
- Captures operands at accept, reads the CSR over the read-only CSR bus, then writes the result over a ready/valid write channel.
- Adds a read timeout, read-only and privilege checks, and registered completion.
- Sits in the execute stage beside the ALU/LSU units and reports rd value or an illegal-instruction exception to writeback.

Parameters:
- XLEN, 32, CSR/register data width.
- TIMEOUT_CYCLES, 16, max cycles waiting for csrbus_rvalid before raising illegal instruction; 0 disables the timeout.
- CHECK_PRIV, 1, enables the read-only and privilege checks on addr[11:8].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  abort the in-flight op
- decode_opcode  in  7  opcode
- decode_funct3  in  3  funct3
- decode_rd  in  5  rd index
- decode_rs1  in  5  rs1 index / zimm
- decode_imm  in  12  CSR address
- read_rs1_val  in  XLEN  rs1 value
- read_valid  in  1  operands valid this cycle
- cur_priv  in  2  current privilege level
- csrbus_araddr  out  12  CSR read address
- csrbus_arvalid  out  1  read request
- csrbus_rdata  in  XLEN  read data
- csrbus_rresp  in  2  0 = OK, else error
- csrbus_rvalid  in  1  read response
- csr_write_addr  out  12  write address
- csr_write_val  out  XLEN  write data
- csr_write_valid  out  1  write request
- csr_write_ready  in  1  write accepted
- processing  out  1  op accepted or in flight
- valid  out  1  completion pulse
- rd_val_out  out  XLEN  rd result
- exception_num_out  out  6  exception cause
- exception_valid_out  out  1  exception with completion

Behaviour:
- States: IDLE, READ, WRITE, RESP. Reset leaves the block in IDLE with every output 0.
- Accept (IDLE only): read_valid && known_opcode && !flush. Latch funct3, rd, rs1, addr and rs1_val; later changes on decode inputs are ignored.
- known_opcode: opcode is SYSTEM and funct3 is in {001, 010, 011, 101, 110, 111}.
- do_read = (rd != 0) || funct3 in {S, C, SI, CI}.
- do_write = funct3 in {W, WI} || rs1 != 0. This differs from the previous unit: CSRRW with rs1 = x0 does write.
- Operand: register forms use rs1_val; immediate forms use the zero-extended 5-bit zimm.
- Check at accept (CHECK_PRIV = 1): exception if (do_write && addr[11:10] == 2'b11) or addr[9:8] > cur_priv. On a failed check go directly to RESP with exception, no bus activity.
- Transitions from IDLE: check fail -> RESP; else do_read -> READ; else -> WRITE.
- READ:
  - csrbus_arvalid = 1, held until csrbus_rvalid. csrbus_araddr = latched addr, held stable.
  - On rvalid with rresp != 0: exception -> RESP.
  - On rvalid with rresp == 0: store rdata; go to WRITE if do_write, else RESP.
  - Timeout counter starts at 0 on entering READ. If it reaches TIMEOUT_CYCLES without rvalid: exception -> RESP, and arvalid drops.
- WRITE:
  - csr_write_valid = 1; addr and val held stable until csr_write_ready; then -> RESP. No write timeout.
  - Write value: W = op; S = rdata | op; C = rdata & ~op. S/C always have do_read = 1, so rdata is valid.
- RESP (exactly one cycle):
  - valid = 1. rd_val_out = read data if do_read, else 0.
  - exception_valid_out = 1 and exception_num_out = 2 on exception, else exception_num_out = 0.
  - Next state IDLE. A new accept is possible the cycle after RESP; no accept in RESP.
- processing = !flush && (accept || state != IDLE).
- Outside RESP: valid, exception_valid_out and exception_num_out are 0. rd_val_out holds its last value, or 0 after reset.
- When not asserted: csr_write_addr and csr_write_val are 0.
- Flush (any state): combinationally gates arvalid, write_valid, valid and exception_valid_out in that cycle, so no write commits and no completion is reported. Next state is IDLE and the timeout counter clears.
- A late rvalid after a flush or timeout, arriving in IDLE, is ignored.
- Reset mid-operation: next cycle in IDLE with all outputs 0.
- Simultaneous rvalid and timeout in the same cycle: rvalid wins.

Test Plan:
- CSRRS rd = 5, rs1 = 3 (rs1_val = 0x0000_00F0), addr 0x300, priv 3; rdata 0x0000_000F after 2 cycles, write_ready immediate -> one write of 0x0000_00FF to 0x300; RESP rd_val_out = 0x0000_000F, valid pulses once.
- CSRRW rd = 0, rs1 = 0, addr 0x340 -> no arvalid; write 0x0 to 0x340 held 3 cycles until ready; valid with rd_val_out = 0 and no exception.
- CSRRWI rd = 1, zimm = 5, addr 0xC00 (read-only) -> no bus traffic; the cycle after accept, valid = 1, exception_valid_out = 1, exception_num_out = 2.
- CSRRC addr 0x300 with cur_priv = 0 -> privilege exception, num 2; separately, rresp = 2'b10 -> exception, no write.
- No rvalid for TIMEOUT_CYCLES = 16 -> arvalid drops, exception 2; a late rvalid in IDLE -> ignored, no valid.
- flush asserted while WRITE is waiting on ready -> write_valid drops the same cycle, no valid; next accept proceeds normally; reset mid-READ -> all outputs 0 on the next cycle.
